// File: rtl/div_frame_seq.sv
// Frame sequencer: 4-byte request from UART RX -> iterative divider -> 4-byte response to UART TX.
// Optional inter-byte idle timeout enabled by defining DIV_TIMEOUT_EN.
module div_frame_seq #(
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              div_start,
  output logic [DATA_W-1:0] div_a,
  output logic [DATA_W-1:0] div_b,
  input  logic              div_done,
  input  logic [DATA_W-1:0] div_q,
  input  logic [DATA_W-1:0] div_r,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              seq_busy,
  output logic              err_dbz,
  output logic              drop
);
  localparam int NB    = DATA_W / 8;
  localparam int FRAME = 2 * NB;
  localparam int CW    = $clog2(FRAME + 1);
  localparam int IW    = $clog2(FRAME);

  localparam logic [2:0] S_RX       = 3'd0;
  localparam logic [2:0] S_DIV_GO   = 3'd1;
  localparam logic [2:0] S_DIV_WAIT = 3'd2;
  localparam logic [2:0] S_TX_LOAD  = 3'd3;
  localparam logic [2:0] S_TX_ACK   = 3'd4;
  localparam logic [2:0] S_TX_DONE  = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, q_q, q_d, r_q, r_d;
  logic                rx_open;
  logic [IW-1:0]       rev;
  logic [2*DATA_W-1:0] resp;

`ifdef DIV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_q, idle_d;
`endif

  // cnt_q == FRAME marks "frame complete, decide next cycle"; extra bytes then are dropped
  assign rx_open = (state_q == S_RX) && (cnt_q != CW'(FRAME));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    q_d       = q_q;
    r_d       = r_q;
    div_start = 1'b0;
    tx_start  = 1'b0;
    err_dbz   = 1'b0;
    drop      = rx_valid && !rx_open;
    case (state_q)
      S_RX: begin
        if (rx_valid && rx_open) begin
          if (cnt_q < CW'(NB)) a_d = {a_q[DATA_W-9:0], rx_data};
          else                 b_d = {b_q[DATA_W-9:0], rx_data};
          cnt_d = cnt_q + CW'(1);
        end else if (cnt_q == CW'(FRAME)) begin
          if (b_q == '0) begin
            q_d     = '1;
            r_d     = a_q;
            err_dbz = 1'b1;
            state_d = S_TX_LOAD;
          end else begin
            state_d = S_DIV_GO;
          end
        end
      end
      S_DIV_GO: begin
        div_start = 1'b1;
        state_d   = S_DIV_WAIT;
      end
      S_DIV_WAIT: begin
        if (div_done) begin
          q_d     = div_q;
          r_d     = div_r;
          state_d = S_TX_LOAD;
        end
      end
      S_TX_LOAD: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = S_TX_ACK;
        end
      end
      S_TX_ACK: begin
        if (tx_busy) state_d = S_TX_DONE;
      end
      S_TX_DONE: begin
        if (!tx_busy) begin
          if (idx_q == IW'(FRAME - 1)) begin
            idx_d   = '0;
            cnt_d   = '0;
            state_d = S_RX;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_TX_LOAD;
          end
        end
      end
      default: state_d = S_RX;
    endcase

`ifdef DIV_TIMEOUT_EN
    idle_d = '0;
    if (state_q == S_RX && cnt_q != '0 && cnt_q != CW'(FRAME) && !rx_valid) begin
      if (idle_q == TW'(TIMEOUT_CYC - 1)) begin
        cnt_d = '0;
        drop  = 1'b1;
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RX;
      cnt_q   <= '0;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
`ifdef DIV_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
`ifdef DIV_TIMEOUT_EN
      idle_q  <= idle_d;
`endif
    end
  end

  // Response bytes go out MSB first: Q hi..lo, then R hi..lo
  assign resp     = {q_q, r_q};
  assign rev      = IW'(FRAME - 1) - idx_q;
  assign tx_data  = resp[{rev, 3'b000} +: 8];
  assign div_a    = a_q;
  assign div_b    = b_q;
  assign seq_busy = !((state_q == S_RX) && (cnt_q == '0));

endmodule

// File: tb/tb_div_frame_seq.sv
// Directed bench for div_frame_seq with behavioural divider and UART TX models.
module tb_div_frame_seq;
  localparam int TO = 40;

  logic        clk, rst, rx_valid, div_start, div_done, tx_start, tx_busy;
  logic        seq_busy, err_dbz, drop;
  logic [7:0]  rx_data, tx_data;
  logic [15:0] div_a, div_b, div_q, div_r;

  div_frame_seq #(.DATA_W(16), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_q(div_q), .div_r(div_r),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .seq_busy(seq_busy), .err_dbz(err_dbz), .drop(drop)
  );

  initial begin clk = 0; forever #5 clk = ~clk; end

  int checks = 0, errors = 0;
  int n_div = 0, n_dbz = 0, n_drop = 0, n_viol = 0, busy_len = 4;
  logic [7:0] tx_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor samples on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      if (tx_start) tx_q.push_back(tx_data);
      if (tx_start && tx_busy) n_viol++;
      if (div_start) n_div++;
      if (err_dbz) n_dbz++;
      if (drop) n_drop++;
    end
  end

  // UART TX model: busy rises one cycle after tx_start, stays busy_len cycles
  initial begin
    tx_busy = 0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        @(posedge clk); #1 tx_busy = 1;
        repeat (busy_len) @(posedge clk);
        #1 tx_busy = 0;
      end
    end
  end

  // Divider model: 3-cycle latency
  initial begin
    logic [15:0] a, b;
    div_done = 0; div_q = 0; div_r = 0;
    forever begin
      @(negedge clk);
      if (div_start) begin
        a = div_a; b = div_b;
        repeat (3) @(posedge clk);
        #1 div_done = 1; div_q = a / b; div_r = a % b;
        @(posedge clk); #1 div_done = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1 rx_valid = 1; rx_data = b;
    @(posedge clk); #1 rx_valid = 0;
  endtask

  task automatic send_frame(input logic [31:0] f);
    for (int j = 0; j < 4; j++) send_byte(f[31-8*j -: 8]);
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (tx_q.size() >= 4 && !seq_busy && !tx_busy) break;
    end
    if (k == 2000) chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic chk_tx(input string name, input logic [31:0] exp);
    chk({name, "_txcnt"}, tx_q.size(), 4);
    for (int j = 0; j < 4; j++)
      chk($sformatf("%s_tx%0d", name, j), (j < tx_q.size()) ? {24'h0, tx_q[j]} : 32'hDEAD,
          {24'h0, exp[31-8*j -: 8]});
  endtask

  typedef struct { logic [31:0] rx; logic [31:0] tx; bit dbz; int busy; } vec_t;
  vec_t vecs[6];

  initial begin
    int d0, z0, p0, k;
    vecs[0] = '{32'h0064_0007, 32'h000E_0002, 1'b0, 4};
    vecs[1] = '{32'h1234_0000, 32'hFFFF_1234, 1'b1, 4};
    vecs[2] = '{32'h000A_0003, 32'h0003_0001, 1'b0, 2};
    vecs[3] = '{32'hFFFF_0001, 32'hFFFF_0000, 1'b0, 50};
    vecs[4] = '{32'h0005_0009, 32'h0000_0005, 1'b0, 4};
    vecs[5] = '{32'h8000_0100, 32'h0080_0000, 1'b0, 3};

    rst = 0; rx_valid = 0; rx_data = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_div_start", div_start, 0); chk("rst_tx_start", tx_start, 0);
    chk("rst_seq_busy", seq_busy, 0);   chk("rst_div_a", div_a, 0);
    @(posedge clk); #1 rst = 1;

    // Latency: 4th rx_valid -> div_start two cycles later
    send_byte(8'h00); send_byte(8'h64); send_byte(8'h00);
    @(posedge clk); #1 rx_valid = 1; rx_data = 8'h07;
    @(negedge clk); chk("lat_c0", div_start, 0);
    @(posedge clk); #1 rx_valid = 0;
    @(negedge clk); chk("lat_c1", div_start, 0);
    @(negedge clk); chk("lat_c2", div_start, 1);
    wait_done("lat");
    tx_q.delete();

    for (int i = 0; i < 6; i++) begin
      string nm = $sformatf("v%0d", i);
      busy_len = vecs[i].busy;
      d0 = n_div; z0 = n_dbz; p0 = n_viol;
      tx_q.delete();
      send_frame(vecs[i].rx);
      wait_done(nm);
      chk({nm, "_ndiv"}, n_div - d0, vecs[i].dbz ? 0 : 1);
      chk({nm, "_ndbz"}, n_dbz - z0, vecs[i].dbz ? 1 : 0);
      chk({nm, "_viol"}, n_viol - p0, 0);
      if (!vecs[i].dbz) begin
        chk({nm, "_div_a"}, div_a, vecs[i].rx[31:16]);
        chk({nm, "_div_b"}, div_b, vecs[i].rx[15:0]);
      end
      chk_tx(nm, vecs[i].tx);
      chk({nm, "_idle"}, seq_busy, 0);
    end

    // Bytes arriving while dividing or transmitting are discarded
    busy_len = 10; tx_q.delete(); p0 = n_drop;
    send_frame(32'h0064_0007);
    for (k = 0; k < 50 && !div_start; k++) @(negedge clk);
    if (k == 50) chk("drop_wait_div", 1, 0);
    send_byte(8'hAA);
    chk("drop_div_wait", n_drop - p0, 1);
    for (k = 0; k < 200 && tx_q.size() < 1; k++) @(negedge clk);
    send_byte(8'hAA);
    chk("drop_tx", n_drop - p0, 2);
    wait_done("drop");
    chk_tx("drop", 32'h000E_0002);

    // Reset mid-response aborts silently
    busy_len = 20; tx_q.delete();
    send_frame(32'h0064_0007);
    for (k = 0; k < 500 && tx_q.size() < 2; k++) @(negedge clk);
    @(posedge clk); #1 rst = 0;
    #1;
    chk("mid_rst_div_a", div_a, 0);    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_seq_busy", seq_busy, 0); chk("mid_rst_tx_start", tx_start, 0);
    repeat (2) @(posedge clk); #1 rst = 1;
    for (k = 0; k < 100 && tx_busy; k++) @(negedge clk);
    tx_q.delete(); busy_len = 4;
    send_frame(32'h000A_0003);
    wait_done("post_rst");
    chk_tx("post_rst", 32'h0003_0001);

`ifdef DIV_TIMEOUT_EN
    tx_q.delete(); p0 = n_drop;
    send_byte(8'h00); send_byte(8'h09);
    repeat (TO + 1) @(posedge clk);
    @(negedge clk);
    chk("to_drop", n_drop - p0, 1);
    chk("to_idle", seq_busy, 0);
    send_frame(32'h0009_0003);
    wait_done("to");
    chk_tx("to", 32'h0003_0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
